conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_seq_ctrl_if.sv | 33 +++
 rtl/conv_addr_gen.sv | 52 +++++
 rtl/conv_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_conv_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding and default geometry for the convolution sequencing controller.
package conv_pkg;

  localparam int unsigned DEF_FILTER_N    = 4;
  localparam int unsigned DEF_LG_FILTER_N = 2;
  localparam int unsigned DEF_VECTOR_N    = 16;
  localparam int unsigned DEF_LG_VECTOR_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT
  } state_e;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Handshake, memory-strobe and accumulator-control bundle of the convolution controller.
interface conv_seq_ctrl_if import conv_pkg::*; #(
  parameter int unsigned LG_FILTER_N = DEF_LG_FILTER_N,
  parameter int unsigned LG_VECTOR_N = DEF_LG_VECTOR_N
) ();

  logic                   start;
  logic                   s_valid;
  logic                   s_ready;
  logic                   wr_en_f;
  logic                   wr_en_x;
  logic [LG_VECTOR_N-1:0] wr_addr;
  logic [LG_VECTOR_N-1:0] rd_addr_x;
  logic [LG_FILTER_N-1:0] rd_addr_f;
  logic                   en_acc;
  logic                   clear_acc;
  logic                   m_valid;
  logic                   m_ready;
  logic                   done;

  modport master (
    input  start, s_valid, m_ready,
    output s_ready, wr_en_f, wr_en_x, wr_addr, rd_addr_x, rd_addr_f,
           en_acc, clear_acc, m_valid, done
  );

  modport slave (
    output start, s_valid, m_ready,
    input  s_ready, wr_en_f, wr_en_x, wr_addr, rd_addr_x, rd_addr_f,
           en_acc, clear_acc, m_valid, done
  );

endinterface

// File: rtl/conv_addr_gen.sv
// Tap (j) and output (k) counters producing the filter/sample read addresses.
module conv_addr_gen import conv_pkg::*; #(
  parameter int unsigned FILTER_N    = DEF_FILTER_N,
  parameter int unsigned LG_FILTER_N = DEF_LG_FILTER_N,
  parameter int unsigned VECTOR_N    = DEF_VECTOR_N,
  parameter int unsigned LG_VECTOR_N = DEF_LG_VECTOR_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   j_inc_i,
  input  logic                   k_inc_i,
  output logic                   j_first_o,
  output logic                   j_last_o,
  output logic                   k_last_o,
  output logic [LG_FILTER_N-1:0] rd_addr_f_o,
  output logic [LG_VECTOR_N-1:0] rd_addr_x_o
);

  localparam logic [LG_FILTER_N-1:0] J_LAST = LG_FILTER_N'(FILTER_N - 1);
  localparam logic [LG_VECTOR_N-1:0] K_LAST = LG_VECTOR_N'(VECTOR_N - FILTER_N);

  logic [LG_FILTER_N-1:0] j_q;
  logic [LG_VECTOR_N-1:0] k_q;
  logic [LG_VECTOR_N-1:0] x_q;

  assign j_first_o   = (j_q == '0);
  assign j_last_o    = (j_q == J_LAST);
  assign k_last_o    = (k_q == K_LAST);
  assign rd_addr_f_o = j_q;
  assign rd_addr_x_o = x_q;

  // x_q tracks k+j incrementally so the sample address is a flop, not an adder output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j_q <= '0;
      k_q <= '0;
      x_q <= '0;
    end else if (clr_i) begin
      j_q <= '0;
      k_q <= '0;
      x_q <= '0;
    end else if (k_inc_i) begin
      k_q <= k_q + LG_VECTOR_N'(1);
      x_q <= k_q + LG_VECTOR_N'(1);
    end else if (j_inc_i) begin
      j_q <= j_last_o ? '0  : j_q + LG_FILTER_N'(1);
      x_q <= j_last_o ? k_q : x_q + LG_VECTOR_N'(1);
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequences load of taps/samples, per-output MAC issue with 1-cycle read latency, and output handshake.
module conv_seq_ctrl import conv_pkg::*; #(
  parameter int unsigned FILTER_N    = DEF_FILTER_N,
  parameter int unsigned LG_FILTER_N = DEF_LG_FILTER_N,
  parameter int unsigned VECTOR_N    = DEF_VECTOR_N,
  parameter int unsigned LG_VECTOR_N = DEF_LG_VECTOR_N
) (
  input  logic            clk,
  input  logic            reset,
  conv_seq_ctrl_if.master bus
);

  localparam int unsigned       LCNT_W    = LG_VECTOR_N + 1;
  localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(FILTER_N + VECTOR_N - 1);
  localparam logic [LCNT_W-1:0] TAPS      = LCNT_W'(FILTER_N);

  state_e              state_q;
  logic [LCNT_W-1:0]   lcnt_q;
  logic                s_ready_q;
  logic                en_acc_q;
  logic                clear_acc_q;
  logic                m_valid_q;

  logic                xfer;
  logic                in_taps;
  logic [LCNT_W-1:0]   x_idx;
  logic                out_xfer;
  logic                j_first;
  logic                j_last;
  logic                k_last;
  logic                j_inc;
  logic                k_inc;
  logic                clr;
  logic [LG_FILTER_N-1:0] rd_addr_f;
  logic [LG_VECTOR_N-1:0] rd_addr_x;

  assign xfer     = bus.s_valid & s_ready_q;
  assign in_taps  = (lcnt_q < TAPS);
  assign x_idx    = lcnt_q - TAPS;
  assign out_xfer = m_valid_q & bus.m_ready;

  // Write strobes follow the transfer directly; the address is held at 0 between transfers.
  assign bus.wr_en_f = xfer & in_taps;
  assign bus.wr_en_x = xfer & ~in_taps;
  assign bus.wr_addr = !xfer  ? '0 :
                       in_taps ? LG_VECTOR_N'(lcnt_q) : LG_VECTOR_N'(x_idx);

  assign bus.s_ready   = s_ready_q;
  assign bus.en_acc    = en_acc_q;
  assign bus.clear_acc = clear_acc_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.done      = out_xfer & k_last;
  assign bus.rd_addr_f = rd_addr_f;
  assign bus.rd_addr_x = rd_addr_x;

  assign j_inc = (state_q == ST_ISSUE);
  assign k_inc = out_xfer & ~k_last;
  assign clr   = (state_q == ST_IDLE) | (out_xfer & k_last);

  conv_addr_gen #(
    .FILTER_N    (FILTER_N),
    .LG_FILTER_N (LG_FILTER_N),
    .VECTOR_N    (VECTOR_N),
    .LG_VECTOR_N (LG_VECTOR_N)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .j_inc_i     (j_inc),
    .k_inc_i     (k_inc),
    .j_first_o   (j_first),
    .j_last_o    (j_last),
    .k_last_o    (k_last),
    .rd_addr_f_o (rd_addr_f),
    .rd_addr_x_o (rd_addr_x)
  );

  // en_acc/clear_acc lag each ISSUE cycle by one to line up with the memory read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lcnt_q      <= '0;
      s_ready_q   <= 1'b0;
      en_acc_q    <= 1'b0;
      clear_acc_q <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      en_acc_q    <= (state_q == ST_ISSUE);
      clear_acc_q <= (state_q == ST_ISSUE) & j_first;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_LOAD;
            lcnt_q    <= '0;
            s_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (lcnt_q == LOAD_LAST) begin
              state_q   <= ST_ISSUE;
              lcnt_q    <= '0;
              s_ready_q <= 1'b0;
            end else begin
              lcnt_q <= lcnt_q + LCNT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (j_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state_q   <= ST_OUT;
          m_valid_q <= 1'b1;
        end
        ST_OUT: begin
          if (out_xfer) begin
            m_valid_q <= 1'b0;
            state_q   <= k_last ? ST_IDLE : ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl with FILTER_N=4, VECTOR_N=8.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int unsigned FN   = 4;
  localparam int unsigned LFN  = 2;
  localparam int unsigned VN   = 8;
  localparam int unsigned LVN  = 3;
  localparam int          NOUT = VN - FN + 1;
  localparam int          NWORDS = FN + VN;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.LG_FILTER_N(LFN), .LG_VECTOR_N(LVN)) bus ();

  conv_seq_ctrl #(
    .FILTER_N(FN), .LG_FILTER_N(LFN), .VECTOR_N(VN), .LG_VECTOR_N(LVN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { bit f; int addr; }         wr_t;
  typedef struct { int x; int f; bit clr; }   iss_t;
  typedef struct { bit start; bit sv; bit e_rdy; bit e_f; bit e_x; int e_addr; } vec_t;

  wr_t  wq[$];
  iss_t iq[$];
  bit   oq[$];
  vec_t tbl[$];

  // Expected read-address stream and output sequence of one complete job.
  task automatic push_job();
    for (int k = 0; k < NOUT; k++) begin
      for (int j = 0; j < FN; j++) iq.push_back('{x: k + j, f: j, clr: (j == 0)});
      oq.push_back(k == NOUT - 1);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  int  cyc = 0, n_acc = 0, issue_start = 0;
  int  prev_x = 0, prev_f = 0;
  bit  prev_mv = 0, prev_mr = 0;
  wr_t  we;
  iss_t ie;
  bit   ol;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (reset) begin
      n_acc = 0; prev_mv = 0; prev_mr = 0; prev_x = 0; prev_f = 0;
    end else begin
      if (bus.wr_en_f || bus.wr_en_x) begin
        check("wr_pending", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          we = wq.pop_front();
          check("wr_en_f", bus.wr_en_f, we.f);
          check("wr_en_x", bus.wr_en_x, !we.f);
          check("wr_addr", bus.wr_addr, we.addr);
        end
      end
      if (bus.clear_acc) begin
        check("clr_with_en", bus.en_acc, 1);
        issue_start = cyc - 1;
      end
      if (bus.en_acc) begin
        check("iss_pending", int'(iq.size() > 0), 1);
        if (iq.size() > 0) begin
          ie = iq.pop_front();
          check("rd_addr_x", prev_x, ie.x);
          check("rd_addr_f", prev_f, ie.f);
          check("clear_acc", bus.clear_acc, ie.clr);
        end
        n_acc++;
      end
      if (bus.m_valid) check("no_acc_in_out", bus.en_acc, 0);
      if (bus.m_valid && !prev_mv) check("mv_latency", cyc - issue_start, FN + 1);
      if (prev_mv && !prev_mr) begin
        check("mv_held", bus.m_valid, 1);
        check("addr_held", bus.rd_addr_x, prev_x);
      end
      if (bus.done) check("done_on_xfer", bus.m_valid & bus.m_ready, 1);
      if (bus.m_valid && bus.m_ready) begin
        check("out_pending", int'(oq.size() > 0), 1);
        if (oq.size() > 0) begin
          ol = oq.pop_front();
          check("acc_per_out", n_acc, FN);
          check("done_last", bus.done, ol);
        end
        n_acc = 0;
      end
      prev_x  = bus.rd_addr_x;
      prev_f  = bus.rd_addr_f;
      prev_mv = bus.m_valid;
      prev_mr = bus.m_ready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   bus.s_ready,   0);
    check({tag, "_wr_en_f"},   bus.wr_en_f,   0);
    check({tag, "_wr_en_x"},   bus.wr_en_x,   0);
    check({tag, "_wr_addr"},   bus.wr_addr,   0);
    check({tag, "_rd_addr_x"}, bus.rd_addr_x, 0);
    check({tag, "_rd_addr_f"}, bus.rd_addr_f, 0);
    check({tag, "_en_acc"},    bus.en_acc,    0);
    check({tag, "_clear_acc"}, bus.clear_acc, 0);
    check({tag, "_m_valid"},   bus.m_valid,   0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  task automatic start_job();
    @(negedge clk);
    bus.start = 1'b1;
    push_job();
    #1 check("start_s_ready", bus.s_ready, 0);
  endtask

  // Back-to-back (or gapped) word stream, then one extra s_valid beat that must not transfer.
  task automatic load_words(input bit gap);
    for (int n = 0; n < NWORDS; n++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.s_valid = 1'b1;
      wq.push_back('{f: (n < FN), addr: (n < FN) ? n : n - FN});
      #1 check("load_s_ready", bus.s_ready, 1);
      if (gap) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b1;
    #1 check("s_ready_drop", bus.s_ready, 0);
  endtask

  // Accept outputs until n_stop transfers; optionally stall one output 3 cycles and poke start there.
  task automatic run_outputs(input int n_stop, input int stall_idx, input bit poke_start);
    int outs = 0, stall = 0, budget = 0;
    while (outs < n_stop && budget < 300) begin
      @(negedge clk);
      budget++;
      bus.s_valid = 1'b0;
      bus.start   = 1'b0;
      if (bus.m_valid && outs == stall_idx && stall < 3) begin
        bus.m_ready = 1'b0;
        stall++;
        if (poke_start && stall == 2) bus.start = 1'b1;
      end else begin
        bus.m_ready = 1'b1;
      end
      #1;
      if (bus.m_valid && bus.m_ready) outs++;
    end
    check("outputs_seen", outs, n_stop);
  endtask

  task automatic end_job(input string tag);
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0; bus.m_ready = 1'b1; bus.s_valid = 1'b0;
      #1;
      check({tag, "_idle_s_ready"}, bus.s_ready, 0);
      check({tag, "_idle_m_valid"}, bus.m_valid, 0);
      check({tag, "_idle_en_acc"},  bus.en_acc,  0);
    end
    check({tag, "_idle_rd_x"}, bus.rd_addr_x, 0);
    check({tag, "_wq_empty"}, wq.size(), 0);
    check({tag, "_iq_empty"}, iq.size(), 0);
    check({tag, "_oq_empty"}, oq.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b1;

    // Job A vectors: idle, start, then gapped load (one word every other cycle).
    tbl.push_back('{start: 0, sv: 0, e_rdy: 0, e_f: 0, e_x: 0, e_addr: 0});
    tbl.push_back('{start: 1, sv: 0, e_rdy: 0, e_f: 0, e_x: 0, e_addr: 0});
    for (int n = 0; n < NWORDS; n++) begin
      tbl.push_back('{start: 0, sv: 1, e_rdy: 1, e_f: (n < FN), e_x: (n >= FN),
                      e_addr: (n < FN) ? n : n - FN});
      tbl.push_back('{start: 0, sv: 0, e_rdy: (n != NWORDS - 1), e_f: 0, e_x: 0, e_addr: 0});
    end

    @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.start   = tbl[i].start;
      bus.s_valid = tbl[i].sv;
      if (tbl[i].start) push_job();
      if (tbl[i].e_f || tbl[i].e_x) wq.push_back('{f: tbl[i].e_f, addr: tbl[i].e_addr});
      #1;
      check($sformatf("vec%0d_s_ready", i), bus.s_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_wr_en_f", i), bus.wr_en_f, tbl[i].e_f);
      check($sformatf("vec%0d_wr_en_x", i), bus.wr_en_x, tbl[i].e_x);
      if (tbl[i].e_f || tbl[i].e_x)
        check($sformatf("vec%0d_wr_addr", i), bus.wr_addr, tbl[i].e_addr);
    end
    run_outputs(NOUT, -1, 1'b0);
    end_job("A");

    // Job B: back-to-back load, output 2 stalled 3 cycles with start poked meanwhile.
    start_job();
    load_words(1'b0);
    run_outputs(NOUT, 1, 1'b1);
    end_job("B");

    // Job C: reset in the middle of issuing output 3.
    start_job();
    load_words(1'b0);
    run_outputs(2, -1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wq.delete(); iq.delete(); oq.delete();
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    #1 check_all_zero("rst_hold");

    // Job D: start on the first edge after reset, stall last output and poke start during it.
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b1;
    push_job();
    #1 check("post_rst_s_ready", bus.s_ready, 0);
    load_words(1'b0);
    run_outputs(NOUT, NOUT - 1, 1'b1);
    end_job("D");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
